// File: rtl/uart_fifo_core.sv
// UART core: baud tick divider, oversampling receiver, transmitter and
// independent RX/TX FIFOs with show-ahead registered heads.

module uart_fifo_buf #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic [W-1:0]  head_reg;
    logic          do_push, do_pop;

    assign full    = count_reg[AW];
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = head_reg;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + (AW+1)'(1);
        else if (!do_push && do_pop)
            count_next = count_reg - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data;
    end

    // The head register bypasses the array when the pushed word becomes the head.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (count_next == '0)
                head_reg <= '0;
            else if (do_push && (empty || (do_pop && count_reg == (AW+1)'(1))))
                head_reg <= push_data;
            else
                head_reg <= mem[rd_ptr_next];
        end
    end
endmodule

module uart_fifo_core #(
    parameter int NBITS   = 8,
    parameter int NTICK   = 16,
    parameter int FIFO_AW = 3,
    parameter int DIV_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIV_W-1:0]   divisor,
    input  logic               parity_en,
    input  logic               parity_odd,
    input  logic               stop2,
    input  logic [NBITS-1:0]   tx_data,
    input  logic               tx_wr,
    output logic               tx_full,
    output logic [FIFO_AW:0]   tx_count,
    output logic               tx_out,
    output logic               tx_busy,
    input  logic               rx_in,
    input  logic               rx_rd,
    output logic [NBITS-1:0]   rx_data,
    output logic               rx_parity_err,
    output logic               rx_frame_err,
    output logic               rx_empty,
    output logic [FIFO_AW:0]   rx_count,
    output logic               rx_overrun,
    input  logic               err_clr
);
    localparam int TW = $clog2(2 * NTICK);
    localparam int BW = $clog2(NBITS + 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(NTICK / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST   = TW'(NTICK - 1);
    localparam logic [TW-1:0] STOP2_LAST = TW'(2 * NTICK - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(NBITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DIV_W-1:0] tick_cnt_reg;
    logic             tick;

    assign tick = (tick_cnt_reg >= divisor);

    always_ff @(posedge clk) begin
        if (rst || tick)
            tick_cnt_reg <= '0;
        else
            tick_cnt_reg <= tick_cnt_reg + DIV_W'(1);
    end

    // ---------------- receiver ----------------
    logic [1:0]       rx_sync_reg;
    logic             rx_s;
    state_t           rx_state_reg;
    logic [TW-1:0]    rx_tick_reg;
    logic [BW-1:0]    rx_bit_reg;
    logic [NBITS-1:0] rx_shift_reg;
    logic             rx_par_en_reg, rx_par_odd_reg, rx_perr_reg;
    logic             rx_push_reg;
    logic [NBITS+1:0] rx_push_data_reg;
    logic             rx_full, rx_overrun_reg;

    assign rx_s = rx_sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst)
            rx_sync_reg <= 2'b11;
        else
            rx_sync_reg <= {rx_sync_reg[0], rx_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg     <= S_IDLE;
            rx_tick_reg      <= '0;
            rx_bit_reg       <= '0;
            rx_shift_reg     <= '0;
            rx_par_en_reg    <= 1'b0;
            rx_par_odd_reg   <= 1'b0;
            rx_perr_reg      <= 1'b0;
            rx_push_reg      <= 1'b0;
            rx_push_data_reg <= '0;
        end else begin
            rx_push_reg <= 1'b0;
            if (tick) begin
                case (rx_state_reg)
                    S_IDLE: if (!rx_s) begin
                        rx_state_reg   <= S_START;
                        rx_tick_reg    <= '0;
                        rx_par_en_reg  <= parity_en;
                        rx_par_odd_reg <= parity_odd;
                        rx_perr_reg    <= 1'b0;
                    end
                    S_START: if (rx_tick_reg == HALF_LAST) begin
                        rx_tick_reg  <= '0;
                        rx_bit_reg   <= '0;
                        rx_state_reg <= rx_s ? S_IDLE : S_DATA;
                    end else
                        rx_tick_reg <= rx_tick_reg + TW'(1);
                    S_DATA: if (rx_tick_reg == BIT_LAST) begin
                        rx_tick_reg  <= '0;
                        rx_shift_reg <= {rx_s, rx_shift_reg[NBITS-1:1]};
                        if (rx_bit_reg == LAST_BIT)
                            rx_state_reg <= rx_par_en_reg ? S_PARITY : S_STOP;
                        else
                            rx_bit_reg <= rx_bit_reg + BW'(1);
                    end else
                        rx_tick_reg <= rx_tick_reg + TW'(1);
                    S_PARITY: if (rx_tick_reg == BIT_LAST) begin
                        rx_tick_reg  <= '0;
                        rx_perr_reg  <= rx_s ^ (^rx_shift_reg) ^ rx_par_odd_reg;
                        rx_state_reg <= S_STOP;
                    end else
                        rx_tick_reg <= rx_tick_reg + TW'(1);
                    S_STOP: if (rx_tick_reg == BIT_LAST) begin
                        rx_tick_reg      <= '0;
                        rx_push_reg      <= 1'b1;
                        rx_push_data_reg <= {rx_perr_reg, !rx_s, rx_shift_reg};
                        rx_state_reg     <= S_IDLE;
                    end else
                        rx_tick_reg <= rx_tick_reg + TW'(1);
                    default: rx_state_reg <= S_IDLE;
                endcase
            end
        end
    end

    uart_fifo_buf #(.W(NBITS + 2), .AW(FIFO_AW)) u_rx_fifo (
        .clk       (clk),
        .srst      (rst),
        .push      (rx_push_reg),
        .push_data (rx_push_data_reg),
        .pop       (rx_rd),
        .head      ({rx_parity_err, rx_frame_err, rx_data}),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // A dropped frame outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)
            rx_overrun_reg <= 1'b0;
        else if (rx_push_reg && rx_full && !rx_rd)
            rx_overrun_reg <= 1'b1;
        else if (err_clr)
            rx_overrun_reg <= 1'b0;
    end
    assign rx_overrun = rx_overrun_reg;

    // ---------------- transmitter ----------------
    state_t           tx_state_reg;
    logic [TW-1:0]    tx_tick_reg, tx_stop_last;
    logic [BW-1:0]    tx_bit_reg;
    logic [NBITS-1:0] tx_shift_reg, tx_head;
    logic             tx_par_en_reg, tx_par_bit_reg, tx_stop2_reg;
    logic             tx_first_reg, tx_out_reg, tx_busy_reg;
    logic             tx_empty, tx_pop;

    assign tx_stop_last = tx_stop2_reg ? STOP2_LAST : BIT_LAST;
    assign tx_pop = !tx_empty && ((tx_state_reg == S_IDLE) ||
                    (tx_state_reg == S_STOP && tick && tx_tick_reg == tx_stop_last));
    assign tx_out  = tx_out_reg;
    assign tx_busy = tx_busy_reg;

    uart_fifo_buf #(.W(NBITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk       (clk),
        .srst      (rst),
        .push      (tx_wr),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg   <= S_IDLE;
            tx_tick_reg    <= '0;
            tx_bit_reg     <= '0;
            tx_shift_reg   <= '0;
            tx_par_en_reg  <= 1'b0;
            tx_par_bit_reg <= 1'b0;
            tx_stop2_reg   <= 1'b0;
            tx_first_reg   <= 1'b0;
            tx_out_reg     <= 1'b1;
            tx_busy_reg    <= 1'b0;
        end else begin
            case (tx_state_reg)
                S_IDLE: if (!tx_empty) begin
                    tx_shift_reg   <= tx_head;
                    tx_par_en_reg  <= parity_en;
                    tx_par_bit_reg <= (^tx_head) ^ parity_odd;
                    tx_stop2_reg   <= stop2;
                    tx_busy_reg    <= 1'b1;
                    tx_first_reg   <= 1'b1;
                    tx_tick_reg    <= '0;
                    tx_state_reg   <= S_START;
                end
                // The first tick after the pop only opens the start bit.
                S_START: if (tick) begin
                    if (tx_first_reg) begin
                        tx_first_reg <= 1'b0;
                        tx_out_reg   <= 1'b0;
                        tx_tick_reg  <= '0;
                    end else if (tx_tick_reg == BIT_LAST) begin
                        tx_tick_reg  <= '0;
                        tx_bit_reg   <= '0;
                        tx_out_reg   <= tx_shift_reg[0];
                        tx_state_reg <= S_DATA;
                    end else
                        tx_tick_reg <= tx_tick_reg + TW'(1);
                end
                S_DATA: if (tick) begin
                    if (tx_tick_reg == BIT_LAST) begin
                        tx_tick_reg <= '0;
                        if (tx_bit_reg == LAST_BIT) begin
                            tx_out_reg   <= tx_par_en_reg ? tx_par_bit_reg : 1'b1;
                            tx_state_reg <= tx_par_en_reg ? S_PARITY : S_STOP;
                        end else begin
                            tx_bit_reg   <= tx_bit_reg + BW'(1);
                            tx_shift_reg <= tx_shift_reg >> 1;
                            tx_out_reg   <= tx_shift_reg[1];
                        end
                    end else
                        tx_tick_reg <= tx_tick_reg + TW'(1);
                end
                S_PARITY: if (tick) begin
                    if (tx_tick_reg == BIT_LAST) begin
                        tx_tick_reg  <= '0;
                        tx_out_reg   <= 1'b1;
                        tx_state_reg <= S_STOP;
                    end else
                        tx_tick_reg <= tx_tick_reg + TW'(1);
                end
                S_STOP: if (tick) begin
                    if (tx_tick_reg == tx_stop_last) begin
                        tx_tick_reg <= '0;
                        if (!tx_empty) begin
                            tx_shift_reg   <= tx_head;
                            tx_par_en_reg  <= parity_en;
                            tx_par_bit_reg <= (^tx_head) ^ parity_odd;
                            tx_stop2_reg   <= stop2;
                            tx_out_reg     <= 1'b0;
                            tx_state_reg   <= S_START;
                        end else begin
                            tx_busy_reg  <= 1'b0;
                            tx_state_reg <= S_IDLE;
                        end
                    end else
                        tx_tick_reg <= tx_tick_reg + TW'(1);
                end
                default: tx_state_reg <= S_IDLE;
            endcase
        end
    end
endmodule
